// File: rtl/i2c_slave_regs.sv
`timescale 1ns/1ps
// i2c_slave_regs: I2C target with a byte-addressed register file,
// filtered SCL/SDA inputs, burst read/write and a host read port.
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int REG_DEPTH  = 16,
  parameter int FILTER_LEN = 3,
  localparam int PTR_W = $clog2(REG_DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             scl,
  inout  wire              sda,
  output logic [7:0]       received_data,
  output logic             data_valid,
  output logic [PTR_W-1:0] wr_ptr,
  output logic             busy,
  output logic [3:0]       state,
  input  logic [PTR_W-1:0] host_rd_addr,
  output logic [7:0]       host_rd_data
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ACK_ADDR, PTR, ACK_PTR,
    WRITE, ACK_WR, READ, RD_ACK, WAIT_STOP
  } st_t;

  st_t st;
  assign state = st;

  logic sda_in;
  assign sda_in = sda;

  // index 0 = scl, index 1 = sda
  logic [1:0] s1, s2, filt, filt_q;
  logic [3:0] cnt [2];

  logic scl_f, sda_f;
  logic scl_rise, scl_fall;
  logic sda_rise, sda_fall;
  logic start_det, stop_det;

  assign scl_f    = filt[0];
  assign sda_f    = filt[1];
  assign scl_rise = filt[0] & ~filt_q[0];
  assign scl_fall = ~filt[0] & filt_q[0];
  assign sda_rise = filt[1] & ~filt_q[1];
  assign sda_fall = ~filt[1] & filt_q[1];
  assign start_det = sda_fall & scl_f;
  assign stop_det  = sda_rise & scl_f;

  // synchronise, glitch-filter and delay both bus lines
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1     <= '1;
      s2     <= '1;
      filt   <= '1;
      filt_q <= '1;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      s1     <= {sda_in, scl};
      s2     <= s1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == 4'(FILTER_LEN - 1)) begin
          filt[i] <= s2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 4'd1;
        end
      end
    end
  end

  logic [7:0]       mem [REG_DEPTH];
  logic [3:0]       bit_cnt;
  logic [6:0]       shreg;
  logic [PTR_W-1:0] ptr;
  logic             sda_oe;
  logic             rw;
  logic [7:0]       byte_in;
  logic [7:0]       rd_byte;
  logic             last_bit;

  assign byte_in  = {shreg, sda_f};
  assign rd_byte  = mem[ptr];
  assign last_bit = (bit_cnt == 4'd7);

  // open-drain: reset releases the line without waiting for a clock
  assign sda = (sda_oe && reset_n) ? 1'b0 : 1'bz;

  // protocol FSM, register file and write reporting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st            <= IDLE;
      bit_cnt       <= '0;
      shreg         <= '0;
      ptr           <= '0;
      sda_oe        <= 1'b0;
      rw            <= 1'b0;
      busy          <= 1'b0;
      data_valid    <= 1'b0;
      received_data <= '0;
      wr_ptr        <= '0;
      for (int i = 0; i < REG_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      data_valid <= 1'b0;
      if (start_det) begin
        st      <= ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else if (stop_det) begin
        st      <= IDLE;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        unique case (st)
          ADDR: if (scl_rise) begin
            shreg   <= byte_in[6:0];
            bit_cnt <= bit_cnt + 4'd1;
            if (last_bit) begin
              bit_cnt <= '0;
              if (byte_in[7:1] == SLAVE_ADDR) begin
                st   <= ACK_ADDR;
                rw   <= byte_in[0];
                busy <= 1'b1;
              end else begin
                st   <= WAIT_STOP;
                busy <= 1'b0;
              end
            end
          end
          ACK_ADDR: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else if (rw) begin
              st     <= READ;
              sda_oe <= ~rd_byte[7];
            end else begin
              st     <= PTR;
              sda_oe <= 1'b0;
            end
          end
          PTR: if (scl_rise) begin
            shreg   <= byte_in[6:0];
            bit_cnt <= bit_cnt + 4'd1;
            if (last_bit) begin
              bit_cnt <= '0;
              ptr     <= byte_in[PTR_W-1:0];
              st      <= ACK_PTR;
            end
          end
          ACK_PTR, ACK_WR: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else begin
              sda_oe <= 1'b0;
              st     <= WRITE;
            end
          end
          WRITE: if (scl_rise) begin
            shreg   <= byte_in[6:0];
            bit_cnt <= bit_cnt + 4'd1;
            if (last_bit) begin
              bit_cnt       <= '0;
              mem[ptr]      <= byte_in;
              received_data <= byte_in;
              wr_ptr        <= ptr;
              data_valid    <= 1'b1;
              ptr           <= ptr + 1'b1;
              st            <= ACK_WR;
            end
          end
          READ: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                st      <= RD_ACK;
              end else begin
                sda_oe <= ~rd_byte[~bit_cnt[2:0]];
              end
            end
          end
          RD_ACK: if (scl_rise) begin
            if (!sda_f) begin
              ptr     <= ptr + 1'b1;
              bit_cnt <= '0;
              st      <= READ;
            end else begin
              st   <= WAIT_STOP;
              busy <= 1'b0;
            end
          end
          IDLE, WAIT_STOP: ;
          default: st <= IDLE;
        endcase
      end
    end
  end

  // registered host-side read of the register file
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      host_rd_data <= '0;
    else
      host_rd_data <= mem[host_rd_addr];
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
`timescale 1ns/1ps
// tb_i2c_slave_regs: directed bus-master bench for i2c_slave_regs,
// table of write transactions plus hand-written corner sequences.
module tb_i2c_slave_regs;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  wire        sda;
  logic [7:0] received_data;
  logic [7:0] host_rd_data;
  logic       data_valid;
  logic       busy;
  logic [3:0] wr_ptr;
  logic [3:0] state;
  logic [3:0] host_rd_addr = 4'd0;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_slave_regs #(
    .SLAVE_ADDR(7'h50),
    .REG_DEPTH(16),
    .FILTER_LEN(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .scl(scl),
    .sda(sda),
    .received_data(received_data),
    .data_valid(data_valid),
    .wr_ptr(wr_ptr),
    .busy(busy),
    .state(state),
    .host_rd_addr(host_rd_addr),
    .host_rd_data(host_rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  int         pulses = 0;
  int         dv_wide = 0;
  int         low_cnt = 0;
  int         busy_cnt = 0;
  logic       dv_prev = 1'b0;
  logic [3:0] wp_q [$];
  logic [7:0] rx_q [$];

  always @(negedge clk) begin
    if (data_valid) begin
      pulses++;
      wp_q.push_back(wr_ptr);
      rx_q.push_back(received_data);
      if (dv_prev) dv_wide++;
    end
    dv_prev = data_valid;
    if (sda === 1'b0 && !m_low) low_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic put_bit(input logic b);
    scl = 1'b0;
    #70 m_low = !b;
    #30 scl = 1'b1;
    #100;
  endtask

  task automatic get_bit(output logic b);
    scl = 1'b0;
    #70 m_low = 1'b0;
    #30 scl = 1'b1;
    #50 b = sda;
    #50;
  endtask

  task automatic do_start();
    scl = 1'b0;
    #70 m_low = 1'b0;
    #30 scl = 1'b1;
    #50 m_low = 1'b1;
    #50;
  endtask

  task automatic do_stop();
    scl = 1'b0;
    #70 m_low = 1'b1;
    #30 scl = 1'b1;
    #50 m_low = 1'b0;
    #50;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    get_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic nack);
    for (int i = 7; i >= 0; i--) get_bit(b[i]);
    put_bit(nack);
  endtask

  task automatic host_read(input logic [3:0] a, input logic [7:0] e);
    host_rd_addr = a;
    #20;
    chk("host_rd", 32'(host_rd_data), 32'(e));
  endtask

  typedef struct {
    logic [7:0] dev;
    logic [7:0] ptr;
    logic [7:0] dat;
    logic       acked;
    logic [3:0] wp;
  } vec_t;

  vec_t v [4];

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic       a0, a1, a2;
    logic [7:0] r0, r1;
    int         p0, l0, b0;

    v[0] = '{8'hA0, 8'h03, 8'h3C, 1'b1, 4'd3};
    v[1] = '{8'hA0, 8'h27, 8'h5A, 1'b1, 4'd7};
    v[2] = '{8'hA2, 8'h55, 8'h66, 1'b0, 4'd0};
    v[3] = '{8'hA0, 8'h00, 8'hFF, 1'b1, 4'd0};

    #50;
    chk("rst_sda", 32'(sda), 1);
    chk("rst_state", 32'(state), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dv", 32'(data_valid), 0);
    reset_n = 1'b1;
    #50;
    chk("rst_rx", 32'(received_data), 0);
    chk("rst_wp", 32'(wr_ptr), 0);
    chk("rst_host", 32'(host_rd_data), 0);

    foreach (v[k]) begin
      p0 = pulses;
      l0 = low_cnt;
      b0 = busy_cnt;
      do_start();
      send_byte(v[k].dev, a0);
      send_byte(v[k].ptr, a1);
      send_byte(v[k].dat, a2);
      do_stop();
      #200;
      if (v[k].acked) begin
        chk("ack_addr", 32'(a0), 0);
        chk("ack_ptr", 32'(a1), 0);
        chk("ack_data", 32'(a2), 0);
        chk("busy_seen", 32'(busy_cnt > b0), 1);
        chk("pulses", pulses - p0, 1);
        if (pulses > p0) begin
          chk("wr_ptr", 32'(wp_q[p0]), 32'(v[k].wp));
          chk("rx_data", 32'(rx_q[p0]), 32'(v[k].dat));
        end
        host_read(v[k].wp, v[k].dat);
      end else begin
        chk("nack_addr", 32'(a0), 1);
        chk("nack_pulses", pulses - p0, 0);
        chk("nack_drive", low_cnt - l0, 0);
        chk("nack_busy", busy_cnt - b0, 0);
      end
      chk("end_idle", 32'(state), 0);
      chk("end_busy", 32'(busy), 0);
    end

    p0 = pulses;
    do_start();
    send_byte(8'hA0, a0);
    send_byte(8'h0F, a1);
    send_byte(8'h11, a2);
    send_byte(8'h22, a2);
    do_stop();
    #200;
    chk("burst_pulses", pulses - p0, 2);
    if (pulses - p0 == 2) begin
      chk("burst_wp0", 32'(wp_q[p0]), 15);
      chk("burst_wp1", 32'(wp_q[p0+1]), 0);
      chk("burst_rx1", 32'(rx_q[p0+1]), 32'h22);
    end
    host_read(4'd15, 8'h11);
    host_read(4'd0, 8'h22);

    do_start();
    send_byte(8'hA0, a0);
    send_byte(8'h03, a0);
    send_byte(8'h3C, a0);
    send_byte(8'h4D, a0);
    do_stop();
    #200;
    do_start();
    send_byte(8'hA0, a0);
    send_byte(8'h03, a1);
    do_start();
    send_byte(8'hA1, a2);
    chk("rd_ack_addr", 32'(a2), 0);
    read_byte(r0, 1'b0);
    read_byte(r1, 1'b1);
    chk("rd_byte0", 32'(r0), 32'h3C);
    chk("rd_byte1", 32'(r1), 32'h4D);
    #100;
    chk("rd_release", 32'(sda), 1);
    chk("rd_busy", 32'(busy), 0);
    chk("rd_wait", 32'(state), 9);
    do_stop();
    #200;
    chk("rd_idle", 32'(state), 0);

    l0 = low_cnt;
    b0 = busy_cnt;
    m_low = 1'b1;
    #20 m_low = 1'b0;
    #100;
    for (int i = 7; i >= 0; i--) put_bit(i == 7 || i == 5);
    chk("glitch_state", 32'(state), 0);
    chk("glitch_busy", busy_cnt - b0, 0);
    chk("glitch_drive", low_cnt - l0, 0);
    do_stop();
    #200;

    p0 = pulses;
    do_start();
    send_byte(8'hA0, a0);
    send_byte(8'h05, a0);
    put_bit(1'b1);
    put_bit(1'b0);
    put_bit(1'b1);
    put_bit(1'b1);
    reset_n = 1'b0;
    m_low = 1'b0;
    #10;
    chk("mid_sda", 32'(sda), 1);
    chk("mid_state", 32'(state), 0);
    chk("mid_busy", 32'(busy), 0);
    #40 reset_n = 1'b1;
    #100;
    chk("mid_pulses", pulses - p0, 0);
    host_read(4'd3, 8'h00);
    host_read(4'd5, 8'h00);
    host_read(4'd15, 8'h00);

    do_start();
    for (int i = 7; i >= 0; i--) put_bit(i == 7 || i == 5);
    scl = 1'b0;
    #70 m_low = 1'b0;
    #30 scl = 1'b1;
    #50;
    chk("ack_drive", 32'(sda), 0);
    reset_n = 1'b0;
    #1;
    chk("ack_rst_release", 32'(sda), 1);
    #49 reset_n = 1'b1;
    #200;

    p0 = pulses;
    do_start();
    send_byte(8'hA0, a0);
    send_byte(8'h05, a1);
    send_byte(8'h77, a2);
    do_stop();
    #200;
    chk("post_ack", 32'({a0, a1, a2}), 0);
    chk("post_pulses", pulses - p0, 1);
    if (pulses > p0) chk("post_wp", 32'(wp_q[p0]), 5);
    host_read(4'd5, 8'h77);
    chk("dv_width", dv_wide, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
